// File: rtl/fpu_operand_sequencer_if.sv
// Operand request and unpacked-result handshake bundle for the FPU front end.
// Ports: req_* (operands in, valid/ready), out_* / op*_ / any_* (unpacked result, valid/ready).
interface fpu_operand_sequencer_if #(
  parameter int FLen   = 32,
  parameter int ExpLen = 8,
  parameter int SigLen = 23
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_nops_i;
  logic [FLen-1:0]   rs1_i;
  logic [FLen-1:0]   rs2_i;
  logic [FLen-1:0]   rs3_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              opa_sign_o;
  logic              opb_sign_o;
  logic              opc_sign_o;
  logic [ExpLen+1:0] opa_exp_o;
  logic [ExpLen+1:0] opb_exp_o;
  logic [ExpLen+1:0] opc_exp_o;
  logic [SigLen:0]   opa_sig_o;
  logic [SigLen:0]   opb_sig_o;
  logic [SigLen:0]   opc_sig_o;
  logic [5:0]        opa_class_o;
  logic [5:0]        opb_class_o;
  logic [5:0]        opc_class_o;
  logic              any_nan_o;
  logic              any_snan_o;

  modport slave (
    input  req_valid_i, req_nops_i,
    input  rs1_i, rs2_i, rs3_i,
    input  out_ready_i,
    output req_ready_o, out_valid_o,
    output opa_sign_o, opb_sign_o, opc_sign_o,
    output opa_exp_o, opb_exp_o, opc_exp_o,
    output opa_sig_o, opb_sig_o, opc_sig_o,
    output opa_class_o, opb_class_o, opc_class_o,
    output any_nan_o, any_snan_o
  );

  modport master (
    output req_valid_i, req_nops_i,
    output rs1_i, rs2_i, rs3_i,
    output out_ready_i,
    input  req_ready_o, out_valid_o,
    input  opa_sign_o, opb_sign_o, opc_sign_o,
    input  opa_exp_o, opb_exp_o, opc_exp_o,
    input  opa_sig_o, opb_sig_o, opc_sig_o,
    input  opa_class_o, opb_class_o, opc_class_o,
    input  any_nan_o, any_snan_o
  );
endinterface

// File: rtl/fpu_operand_sequencer.sv
// FPU operand sequencer: time-shares one external classifier over 1-3 operands.
// Ports: clk_i, resetn_i, flush_i, bus (slave handshake bundle), cls_* classifier link.
module fpu_operand_sequencer #(
  parameter int FLen   = 32,
  parameter int ExpLen = 8,
  parameter int SigLen = 23
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    flush_i,
  fpu_operand_sequencer_if.slave  bus,
  output logic [FLen-1:0]         cls_reg_o,
  input  logic [ExpLen+1:0]       cls_exp_i,
  input  logic [SigLen:0]         cls_sig_i,
  input  logic [5:0]              cls_class_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] ClsZero = 6'b000001;

  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] n_q, n_d;

  logic [2:0][FLen-1:0]   rs_q, rs_d;
  logic [2:0]             sign_q, sign_d;
  logic [2:0][ExpLen+1:0] exp_q, exp_d;
  logic [2:0][SigLen:0]   sig_q, sig_d;
  logic [2:0][5:0]        cls_q, cls_d;
  logic                   nan_q, nan_d;
  logic                   snan_q, snan_d;

  logic [FLen-1:0] op_sel;

  always_comb begin
    op_sel = rs_q[0];
    unique case (idx_q)
      2'd0:    op_sel = rs_q[0];
      2'd1:    op_sel = rs_q[1];
      default: op_sel = rs_q[2];
    endcase
  end

  assign cls_reg_o = (state_q == S_DEC) ? op_sel : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    rs_d    = rs_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    cls_d   = cls_q;
    nan_d   = nan_q;
    snan_d  = snan_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          rs_d    = {bus.rs3_i, bus.rs2_i, bus.rs1_i};
          n_d     = (bus.req_nops_i == 2'd0) ? 2'd1 : bus.req_nops_i;
          sign_d  = '0;
          exp_d   = '0;
          sig_d   = '0;
          cls_d   = {ClsZero, ClsZero, ClsZero};
          nan_d   = 1'b0;
          snan_d  = 1'b0;
          idx_d   = 2'd0;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        for (int i = 0; i < 3; i++) begin
          if (idx_q == 2'(i)) begin
            sign_d[i] = op_sel[FLen-1];
            exp_d[i]  = cls_exp_i;
            sig_d[i]  = cls_sig_i;
            cls_d[i]  = cls_class_i;
          end
        end
        nan_d  = nan_q | cls_class_i[5] | cls_class_i[4];
        snan_d = snan_q | cls_class_i[4];
        // idx stays on the last slot rather than wrapping
        if (idx_q == n_q - 2'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      rs_q    <= '0;
      sign_q  <= '0;
      exp_q   <= '0;
      sig_q   <= '0;
      cls_q   <= '0;
      nan_q   <= 1'b0;
      snan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      rs_q    <= rs_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      cls_q   <= cls_d;
      nan_q   <= nan_d;
      snan_q  <= snan_d;
    end
  end

  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.out_valid_o = (state_q == S_DONE);
  assign bus.opa_sign_o  = sign_q[0];
  assign bus.opb_sign_o  = sign_q[1];
  assign bus.opc_sign_o  = sign_q[2];
  assign bus.opa_exp_o   = exp_q[0];
  assign bus.opb_exp_o   = exp_q[1];
  assign bus.opc_exp_o   = exp_q[2];
  assign bus.opa_sig_o   = sig_q[0];
  assign bus.opb_sig_o   = sig_q[1];
  assign bus.opc_sig_o   = sig_q[2];
  assign bus.opa_class_o = cls_q[0];
  assign bus.opb_class_o = cls_q[1];
  assign bus.opc_class_o = cls_q[2];
  assign bus.any_nan_o   = nan_q;
  assign bus.any_snan_o  = snan_q;

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Testbench for fpu_operand_sequencer with a behavioural FP32 classifier.
// Ports: none (top-level bench).
module tb_fpu_operand_sequencer;

  localparam logic [5:0] QNAN = 6'b100000;
  localparam logic [5:0] SNAN = 6'b010000;
  localparam logic [5:0] INF  = 6'b001000;
  localparam logic [5:0] NORM = 6'b000100;
  localparam logic [5:0] SUB  = 6'b000010;
  localparam logic [5:0] ZERO = 6'b000001;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  logic [31:0] cls_reg;
  logic [9:0]  cls_exp;
  logic [23:0] cls_sig;
  logic [5:0]  cls_class;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_operand_sequencer_if #(.FLen(32), .ExpLen(8), .SigLen(23)) bus ();

  fpu_operand_sequencer #(.FLen(32), .ExpLen(8), .SigLen(23)) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .flush_i     (flush),
    .bus         (bus),
    .cls_reg_o   (cls_reg),
    .cls_exp_i   (cls_exp),
    .cls_sig_i   (cls_sig),
    .cls_class_i (cls_class)
  );

  always_comb begin
    logic [7:0]  e;
    logic [22:0] f;
    int p;
    e = cls_reg[30:23];
    f = cls_reg[22:0];
    p = 0;
    cls_exp = '0;
    cls_sig = '0;
    cls_class = ZERO;
    if (e == 8'd0 && f == 23'd0) begin
      cls_class = ZERO;
    end else if (e == 8'd0) begin
      for (int i = 0; i < 23; i++) if (f[i]) p = i;
      cls_exp = 10'(-149 + p);
      cls_sig = 24'(f) << (23 - p);
      cls_class = SUB;
    end else if (e == 8'hFF) begin
      cls_exp = 10'd128;
      cls_sig = {1'b1, f};
      cls_class = (f == 23'd0) ? INF : (f[22] ? QNAN : SNAN);
    end else begin
      cls_exp = 10'(int'(e) - 127);
      cls_sig = {1'b1, f};
      cls_class = NORM;
    end
  end

  typedef struct {
    logic [1:0]       nops;
    logic [31:0]      rs1, rs2, rs3;
    int               lat;
    logic [2:0]       sign;
    logic [2:0][9:0]  ex;
    logic [2:0][23:0] sg;
    logic [2:0][5:0]  cl;
    logic             nan, snan;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int v, input logic [1:0] n,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input int lat,
                         input logic nan, input logic snan);
    vecs[v].nops = n;
    vecs[v].rs1 = a;
    vecs[v].rs2 = b;
    vecs[v].rs3 = c;
    vecs[v].lat = lat;
    vecs[v].nan = nan;
    vecs[v].snan = snan;
    vecs[v].sign = '0;
    vecs[v].ex = '0;
    vecs[v].sg = '0;
    vecs[v].cl = {ZERO, ZERO, ZERO};
  endtask

  task automatic set_slot(input int v, input int s, input logic sb,
                          input logic [9:0] e, input logic [23:0] m,
                          input logic [5:0] c);
    vecs[v].sign[s] = sb;
    vecs[v].ex[s] = e;
    vecs[v].sg[s] = m;
    vecs[v].cl[s] = c;
  endtask

  task automatic check_out(input int v, input string tag);
    chk({tag, " a_sign"}, 32'(bus.opa_sign_o), 32'(vecs[v].sign[0]));
    chk({tag, " b_sign"}, 32'(bus.opb_sign_o), 32'(vecs[v].sign[1]));
    chk({tag, " c_sign"}, 32'(bus.opc_sign_o), 32'(vecs[v].sign[2]));
    chk({tag, " a_exp"}, 32'(bus.opa_exp_o), 32'(vecs[v].ex[0]));
    chk({tag, " b_exp"}, 32'(bus.opb_exp_o), 32'(vecs[v].ex[1]));
    chk({tag, " c_exp"}, 32'(bus.opc_exp_o), 32'(vecs[v].ex[2]));
    chk({tag, " a_sig"}, 32'(bus.opa_sig_o), 32'(vecs[v].sg[0]));
    chk({tag, " b_sig"}, 32'(bus.opb_sig_o), 32'(vecs[v].sg[1]));
    chk({tag, " c_sig"}, 32'(bus.opc_sig_o), 32'(vecs[v].sg[2]));
    chk({tag, " a_class"}, 32'(bus.opa_class_o), 32'(vecs[v].cl[0]));
    chk({tag, " b_class"}, 32'(bus.opb_class_o), 32'(vecs[v].cl[1]));
    chk({tag, " c_class"}, 32'(bus.opc_class_o), 32'(vecs[v].cl[2]));
    chk({tag, " any_nan"}, 32'(bus.any_nan_o), 32'(vecs[v].nan));
    chk({tag, " any_snan"}, 32'(bus.any_snan_o), 32'(vecs[v].snan));
  endtask

  task automatic drive_req(input int v);
    bus.req_valid_i = 1'b1;
    bus.req_nops_i = vecs[v].nops;
    bus.rs1_i = vecs[v].rs1;
    bus.rs2_i = vecs[v].rs2;
    bus.rs3_i = vecs[v].rs3;
  endtask

  task automatic wait_valid(input int v, input string tag);
    int cnt;
    cnt = 0;
    while (!bus.out_valid_o && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " latency"}, 32'(cnt), 32'(vecs[v].lat));
  endtask

  task automatic release_out(input string tag);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    chk({tag, " valid_drop"}, 32'(bus.out_valid_o), 32'd0);
    chk({tag, " ready_back"}, 32'(bus.req_ready_o), 32'd1);
  endtask

  task automatic run_vec(input int v);
    string tag;
    tag = $sformatf("v%0d", v);
    @(negedge clk);
    chk({tag, " req_ready"}, 32'(bus.req_ready_o), 32'd1);
    drive_req(v);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk({tag, " cls_reg"}, cls_reg, vecs[v].rs1);
    wait_valid(v, tag);
    check_out(v, tag);
    release_out(tag);
  endtask

  initial begin
    set_vec(0, 2'd2, 32'h3F800000, 32'h00000001, 32'h0, 2, 1'b0, 1'b0);
    set_slot(0, 0, 1'b0, 10'h000, 24'h800000, NORM);
    set_slot(0, 1, 1'b0, 10'h36B, 24'h800000, SUB);

    set_vec(1, 2'd3, 32'h3F800000, 32'h00000001, 32'h7F800001, 3, 1'b1, 1'b1);
    set_slot(1, 0, 1'b0, 10'h000, 24'h800000, NORM);
    set_slot(1, 1, 1'b0, 10'h36B, 24'h800000, SUB);
    set_slot(1, 2, 1'b0, 10'h080, 24'h800001, SNAN);

    set_vec(2, 2'd3, 32'h3F800000, 32'h00000001, 32'h7FC00000, 3, 1'b1, 1'b0);
    set_slot(2, 0, 1'b0, 10'h000, 24'h800000, NORM);
    set_slot(2, 1, 1'b0, 10'h36B, 24'h800000, SUB);
    set_slot(2, 2, 1'b0, 10'h080, 24'hC00000, QNAN);

    set_vec(3, 2'd0, 32'h80000000, 32'h3F800000, 32'h7F800001, 1, 1'b0, 1'b0);
    set_slot(3, 0, 1'b1, 10'h000, 24'h000000, ZERO);

    set_vec(4, 2'd1, 32'hC0000000, 32'h0, 32'h0, 1, 1'b0, 1'b0);
    set_slot(4, 0, 1'b1, 10'h001, 24'h800000, NORM);

    set_vec(5, 2'd2, 32'hFF800000, 32'h00400000, 32'h7F800001, 2, 1'b0, 1'b0);
    set_slot(5, 0, 1'b1, 10'h080, 24'h800000, INF);
    set_slot(5, 1, 1'b0, 10'h381, 24'h800000, SUB);

    resetn = 1'b0;
    flush = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_nops_i = 2'd0;
    bus.rs1_i = '0;
    bus.rs2_i = '0;
    bus.rs3_i = '0;
    bus.out_ready_i = 1'b0;
    #3;
    chk("rst req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst a_class", 32'(bus.opa_class_o), 32'd0);
    chk("rst any_nan", 32'(bus.any_nan_o), 32'd0);
    chk("rst cls_reg", cls_reg, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(v);

    // back-pressure in DONE with a competing request
    @(negedge clk);
    drive_req(1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    wait_valid(1, "hold");
    drive_req(4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d req_ready", k), 32'(bus.req_ready_o), 32'd0);
      chk($sformatf("hold%0d out_valid", k), 32'(bus.out_valid_o), 32'd1);
      check_out(1, $sformatf("hold%0d", k));
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    chk("hold release valid", 32'(bus.out_valid_o), 32'd0);
    chk("hold release ready", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("hold accept busy", 32'(bus.req_ready_o), 32'd0);
    wait_valid(4, "hold2");
    check_out(4, "hold2");
    release_out("hold2");

    // flush during DEC at idx 1
    @(negedge clk);
    drive_req(1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("flush cls_reg idx1", cls_reg, 32'h00000001);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("flush out_valid", 32'(bus.out_valid_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("flush quiet%0d", k), 32'(bus.out_valid_o), 32'd0);
    end

    // flush beats a request in IDLE
    drive_req(0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.req_valid_i = 1'b0;
    chk("flush idle no accept", 32'(bus.req_ready_o), 32'd1);
    run_vec(0);

    // async reset between edges mid-DEC
    @(negedge clk);
    drive_req(2);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("pre-reset a_class", 32'(bus.opa_class_o), 32'(NORM));
    #2;
    resetn = 1'b0;
    #1;
    chk("areset out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("areset req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("areset cls_reg", cls_reg, 32'd0);
    chk("areset a_sig", 32'(bus.opa_sig_o), 32'd0);
    chk("areset a_class", 32'(bus.opa_class_o), 32'd0);
    chk("areset b_class", 32'(bus.opb_class_o), 32'd0);
    chk("areset any_nan", 32'(bus.any_nan_o), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_vec(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
